int_prio_arb: RTL and testbench
===============================

# int_prio_arb

Interrupt priority arbiter. Sits downstream of the per-source interrupt detection stage in the CPU clock domain. Consumes the already-synchronised per-source pending vector, picks one source by fixed or round-robin priority, and presents a single request with a vector number to the CPU. It runs an acknowledge / end-of-interrupt handshake and emits a one-cycle clear pulse back to the detection stage for the acknowledged source.

## Interface
- N, default 5: number of interrupt sources.
- VEC_W, default 3: vector width; must satisfy 2^VEC_W >= N.

Ports:
- clk  in  1  block clock.
- resetn  in  1  reset; asynchronous, active-low.
- int_pend  in  N  per-source pending state, synchronous to clk.
- int_mask  in  N  1 = source masked (not eligible).
- rr_en  in  1  priority mode: 0 = fixed, lowest index highest; 1 = round-robin.
- irq  out  1  interrupt request to CPU.
- irq_vec  out  VEC_W  index of the requesting source; stable while irq = 1.
- irq_ack  in  1  single-cycle CPU acknowledge.
- eoi  in  1  single-cycle end-of-interrupt from CPU.
- int_clr  out  N  one-hot, one-cycle clear pulse to the detection stage.
- in_service  out  N  one-hot source currently being serviced.

## Operation
- eligible = int_pend & ~int_mask, evaluated combinationally each cycle.
- Winner selection:
  - Fixed mode: lowest set index of eligible.
  - Round-robin mode: first set index at or above rr_ptr, wrapping modulo N.
  - rr_ptr resets to 0. It is updated only on eoi, to (serviced index + 1) mod N; index N-1 wraps to 0.
  - rr_en is sampled only in IDLE when a winner is chosen.
- FSM states: IDLE, REQ, SERVICE.
  - **IDLE:** irq = 0. If eligible != 0, register the winner into irq_vec and go to REQ.
  - **REQ:** irq = 1, irq_vec held.
    - If irq_ack: set in_service = onehot(irq_vec), pulse int_clr = onehot(irq_vec) for exactly one cycle, go to SERVICE.
    - Else if eligible[irq_vec] = 0 (source withdrew or was masked): go to IDLE with no clear pulse and no in_service.
    - irq_ack in the same cycle as a withdrawal: the ack wins.
  - **SERVICE:** irq = 0. On eoi, clear in_service, update rr_ptr, go to IDLE.
- Ignored inputs:
  - irq_ack outside REQ and eoi outside SERVICE are ignored.
  - A new eligible source during SERVICE waits; there is no nesting or pre-emption.
  - Mask or pending changes during SERVICE do not alter in_service.
- Level sources still pending after eoi re-request normally. int_clr clears edge-latched sources only.
- irq_vec keeps its last value when irq = 0.

## Timing
- Reset (asynchronous, any state): FSM = IDLE, irq = 0, irq_vec = 0, int_clr = 0, in_service = 0, rr_ptr = 0. An int_clr pulse in flight is cancelled.
- All outputs are registered.
- Request latency:
  - eligible sampled at edge k in IDLE gives irq = 1 and a valid irq_vec after edge k (1 cycle).
- Acknowledge:
  - irq_ack sampled at edge k in REQ gives int_clr pulse and in_service set after edge k.
  - irq falls after edge k, and int_clr is low again after edge k+1.
- Withdrawal: eligible[irq_vec] low at edge k in REQ gives irq = 0 after edge k.
- EOI turnaround:
  - eoi sampled at edge k clears in_service after edge k.
  - Earliest next irq is after edge k+1, so there is at least one cycle with irq = 0 between services.
- Highest throughput is one service per 3 cycles (IDLE, REQ with ack, SERVICE with eoi).

## Test plan
- **Fixed priority:** rr_en=0, int_pend=5'b10110, mask=0 → irq=1, irq_vec=1. Then ack → int_clr=5'b00010 for one cycle and in_service=5'b00010. Then eoi → irq_vec=2 two cycles later.
- **Round-robin:** rr_en=1, int_pend held at 5'b10011, ack+eoi each grant → vectors served in order 0,1,4,0. rr_ptr wraps from 4 to 0.
- **Mask/withdraw:** in REQ with irq_vec=3, set int_mask[3]=1 with no ack → irq=0 next cycle, int_clr stays 0, FSM returns to IDLE. With int_pend=5'b01000 → no new irq.
- **Simultaneous ack and withdraw:** in REQ with irq_vec=2, assert irq_ack and drop int_pend[2] in the same cycle → int_clr=5'b00100 and in_service=5'b00100.
- **Stray handshakes:** eoi in IDLE/REQ and irq_ack in SERVICE → no state change, no int_clr.
- **Reset mid-service:** in SERVICE with in_service=5'b00001, assert resetn=0 asynchronously → all outputs 0 immediately. After release with int_pend=5'b00001 → irq=1, irq_vec=0 one cycle later, rr_ptr=0.

Source files
------------

// File: rtl/int_prio_arb.sv
// Interrupt priority arbiter: selects one eligible source (fixed or round-robin),
// presents it to the CPU, and runs the ack / end-of-interrupt handshake.
module int_prio_arb #(
  parameter int unsigned N     = 5,
  parameter int unsigned VEC_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     int_pend,
  input  logic [N-1:0]     int_mask,
  input  logic             rr_en,
  output logic             irq,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic [N-1:0]     int_clr,
  output logic [N-1:0]     in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             irq_d;
  logic [VEC_W-1:0] vec_d;
  logic [N-1:0]     clr_d;
  logic [N-1:0]     svc_d;
  logic [VEC_W-1:0] rr_ptr, ptr_d;

  logic [N-1:0]     eligible;
  logic [VEC_W-1:0] win_vec;
  logic [N-1:0]     cur_onehot;

  assign eligible   = int_pend & ~int_mask;
  assign cur_onehot = N'(1) << irq_vec;

  // Scan N positions starting at the base index, wrapping modulo N; the
  // first eligible hit wins. Fixed mode is simply a scan from index 0.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic        found;
    win_vec = '0;
    found   = 1'b0;
    base    = rr_en ? 32'(rr_ptr) : 32'd0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = base + i;
      if (idx >= N) idx = idx - N;
      if (!found && eligible[idx[VEC_W-1:0]]) begin
        found   = 1'b1;
        win_vec = idx[VEC_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    vec_d   = irq_vec;
    clr_d   = '0;
    svc_d   = in_service;
    ptr_d   = rr_ptr;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          vec_d   = win_vec;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence over a same-cycle withdrawal.
        if (irq_ack) begin
          svc_d   = cur_onehot;
          clr_d   = cur_onehot;
          state_d = SERVICE;
        end else if (!eligible[irq_vec]) begin
          state_d = IDLE;
        end else begin
          irq_d = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi) begin
          svc_d   = '0;
          ptr_d   = (irq_vec == VEC_W'(N - 1)) ? '0 : irq_vec + VEC_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      irq        <= 1'b0;
      irq_vec    <= '0;
      int_clr    <= '0;
      in_service <= '0;
      rr_ptr     <= '0;
    end else begin
      state_q    <= state_d;
      irq        <= irq_d;
      irq_vec    <= vec_d;
      int_clr    <= clr_d;
      in_service <= svc_d;
      rr_ptr     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_int_prio_arb.sv
// Directed bench for int_prio_arb: fixed/round-robin selection, handshakes,
// withdrawal, stray handshakes and asynchronous reset mid-service.
module tb_int_prio_arb;

  logic       clk;
  logic       resetn;
  logic [4:0] int_pend;
  logic [4:0] int_mask;
  logic       rr_en;
  logic       irq;
  logic [2:0] irq_vec;
  logic       irq_ack;
  logic       eoi;
  logic [4:0] int_clr;
  logic [4:0] in_service;

  int unsigned vectors;
  int unsigned miscompares;

  int_prio_arb #(.N(5), .VEC_W(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .int_pend   (int_pend),
    .int_mask   (int_mask),
    .rr_en      (rr_en),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .int_clr    (int_clr),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_irq, input logic [2:0] e_vec,
                         input logic [4:0] e_clr, input logic [4:0] e_svc);
    chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
    chk({tag, ".vec"}, 32'(irq_vec), 32'(e_vec));
    chk({tag, ".clr"}, 32'(int_clr), 32'(e_clr));
    chk({tag, ".svc"}, 32'(in_service), 32'(e_svc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] rr_exp [4];
    rr_exp = '{3'd0, 3'd1, 3'd4, 3'd0};
    vectors = 0;
    miscompares = 0;
    resetn = 1'b0; int_pend = '0; int_mask = '0; rr_en = 1'b0;
    irq_ack = 1'b0; eoi = 1'b0;
    #12;
    chk_out("reset", 1'b0, 3'd0, 5'b00000, 5'b00000);
    resetn = 1'b1;

    // Fixed priority
    int_pend = 5'b10110;
    step();
    chk_out("fix_req", 1'b1, 3'd1, 5'b00000, 5'b00000);
    irq_ack = 1'b1;
    step();
    chk_out("fix_ack", 1'b0, 3'd1, 5'b00010, 5'b00010);
    irq_ack = 1'b0; int_pend = 5'b10100;
    step();
    chk_out("fix_svc", 1'b0, 3'd1, 5'b00000, 5'b00010);
    irq_ack = 1'b1;  // stray ack in SERVICE
    step();
    chk_out("stray_ack", 1'b0, 3'd1, 5'b00000, 5'b00010);
    irq_ack = 1'b0; eoi = 1'b1;
    step();
    chk_out("fix_eoi", 1'b0, 3'd1, 5'b00000, 5'b00000);
    eoi = 1'b0;
    step();
    chk_out("fix_next", 1'b1, 3'd2, 5'b00000, 5'b00000);
    eoi = 1'b1;      // stray eoi in REQ
    step();
    chk_out("stray_eoi_req", 1'b1, 3'd2, 5'b00000, 5'b00000);
    eoi = 1'b0;

    // Ack and withdrawal in the same cycle
    irq_ack = 1'b1; int_pend = 5'b10000;
    step();
    chk_out("ack_wd", 1'b0, 3'd2, 5'b00100, 5'b00100);
    irq_ack = 1'b0; int_pend = 5'b00000; eoi = 1'b1;
    step();
    chk_out("ack_wd_eoi", 1'b0, 3'd2, 5'b00000, 5'b00000);
    step();          // stray eoi in IDLE, nothing pending
    chk_out("stray_eoi_idle", 1'b0, 3'd2, 5'b00000, 5'b00000);
    eoi = 1'b0;

    // Round-robin from a fresh pointer
    resetn = 1'b0; #2; resetn = 1'b1;
    rr_en = 1'b1; int_pend = 5'b10011;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("rr%0d_req", i), 1'b1, rr_exp[i], 5'b00000, 5'b00000);
      irq_ack = 1'b1;
      step();
      chk_out($sformatf("rr%0d_ack", i), 1'b0, rr_exp[i], 5'(5'b00001 << rr_exp[i]),
              5'(5'b00001 << rr_exp[i]));
      irq_ack = 1'b0; eoi = 1'b1;
      step();
      eoi = 1'b0;
    end

    // Mask while requesting
    rr_en = 1'b0; int_pend = 5'b01000;
    step();
    chk_out("mask_req", 1'b1, 3'd3, 5'b00000, 5'b00000);
    int_mask = 5'b01000;
    step();
    chk_out("mask_wd", 1'b0, 3'd3, 5'b00000, 5'b00000);
    step();
    step();
    chk_out("mask_idle", 1'b0, 3'd3, 5'b00000, 5'b00000);

    // Asynchronous reset mid-service; round-robin pointer must be back at 0
    int_mask = '0; int_pend = 5'b00001;
    step();
    chk_out("rst_req", 1'b1, 3'd0, 5'b00000, 5'b00000);
    irq_ack = 1'b1;
    step();
    chk_out("rst_svc", 1'b0, 3'd0, 5'b00001, 5'b00001);
    irq_ack = 1'b0; int_pend = 5'b00110;
    step();
    chk_out("rst_svc2", 1'b0, 3'd0, 5'b00000, 5'b00001);
    resetn = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 3'd0, 5'b00000, 5'b00000);
    #1;
    resetn = 1'b1; rr_en = 1'b1; int_pend = 5'b00011;
    step();
    chk_out("rst_after", 1'b1, 3'd0, 5'b00000, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
